// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-bus handshake between the fetch stage (master) and the
//   instruction memory / cache (slave). There is at most one request in flight.
//
//   ireq_valid     master -> slave  request valid
//   ireq_addr      master -> slave  word-aligned request address (held stable
//                                   until iresp_data_ok)
//   iresp_data_ok  slave -> master  response for the outstanding request
//   iresp_data     slave -> master  instruction word, valid with iresp_data_ok
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC, issues
//   one instruction-bus request at a time, and applies stalls and branch/jump
//   redirects coming from later stages.
//
//   clk             pipeline clock, rising edge
//   reset           asynchronous active-high reset
//   ibus            instruction-bus handshake (master side)
//   stallF          hazard unit: hold fetch output, do not advance
//   redirect_valid  branch/jump taken; refetch from redirect_pc
//   redirect_pc     redirect target (low two bits ignored)
//   f_d_reg         {pc_plus_4, instruction}; 64'h0 is a bubble (NOP)
//   fetch_busy      request in flight and no data this cycle
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        ibus,
  input  logic                 stallF,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [63:0]          f_d_reg,
  output logic                 fetch_busy
);

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
  } f_d_reg_t;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,  // request issued, awaiting data
    ST_HOLD    = 2'd1,  // instruction buffered while decode is stalled
    ST_DISCARD = 2'd2   // waiting to drop a response made stale by a redirect
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] discard_pc_reg, discard_pc_next;
  logic [31:0] buf_data_reg, buf_data_next;

  logic [31:0] pc_plus_4;
  logic [31:0] redirect_target;
  logic        data_ok;

  logic        req_valid_c;
  logic [31:0] req_addr_c;
  f_d_reg_t    f_d_c;
  logic        busy_c;

  assign pc_plus_4       = pc_reg + 32'd4;   // wraps modulo 2^32
  assign redirect_target = redirect_pc & ~32'h3;
  assign data_ok         = ibus.iresp_data_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_REQ;
      pc_reg         <= RESET_PC;
      discard_pc_reg <= 32'h0;
      buf_data_reg   <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      discard_pc_reg <= discard_pc_next;
      buf_data_reg   <= buf_data_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    discard_pc_next = discard_pc_reg;
    buf_data_next   = buf_data_reg;
    req_valid_c     = 1'b0;
    req_addr_c      = pc_reg;
    f_d_c           = '0;
    busy_c          = 1'b0;

    unique case (state_reg)
      ST_REQ: begin
        req_valid_c = 1'b1;
        busy_c      = !data_ok;
        if (redirect_valid) begin
          // Redirect beats everything: any arriving word is on the wrong path.
          pc_next = redirect_target;
          if (!data_ok) begin
            // The bus still owes us a response for pc; drop it when it comes.
            discard_pc_next = pc_reg;
            state_next      = ST_DISCARD;
          end
        end else if (data_ok && !stallF) begin
          f_d_c.pc_plus_4   = pc_plus_4;
          f_d_c.instruction = ibus.iresp_data;
          pc_next           = pc_plus_4;
        end else if (data_ok) begin
          buf_data_next = ibus.iresp_data;
          state_next    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        f_d_c.pc_plus_4   = pc_plus_4;
        f_d_c.instruction = buf_data_reg;
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = ST_REQ;
        end else if (!stallF) begin
          // Decode captures the buffered word on this edge.
          pc_next    = pc_plus_4;
          state_next = ST_REQ;
        end
      end

      ST_DISCARD: begin
        // Keep the stale request on the bus so the slave sees a stable address.
        req_valid_c = 1'b1;
        req_addr_c  = discard_pc_reg;
        busy_c      = !data_ok;
        if (redirect_valid) begin
          pc_next = redirect_target;
        end
        if (data_ok) begin
          state_next = ST_REQ;
        end
      end

      default: begin
        state_next = ST_REQ;
      end
    endcase

    // Outputs are forced quiet while reset is held, independent of the clock.
    if (reset) begin
      req_valid_c = 1'b0;
      f_d_c       = '0;
      busy_c      = 1'b0;
    end
  end

  assign ibus.ireq_valid = req_valid_c;
  assign ibus.ireq_addr  = req_addr_c;
  assign f_d_reg         = f_d_c;
  assign fetch_busy      = busy_c;

endmodule
